// File: rtl/demux4_router_pkg.sv
// demux4_router shared definitions: lane encoding and select decode.
// The decode is shared with the 4:1 mux bench for loopback checks.
package demux4_router_pkg;

    typedef logic [1:0] lane_t;

    localparam lane_t LANE1 = 2'b00;
    localparam lane_t LANE2 = 2'b01;
    localparam lane_t LANE3 = 2'b10;
    localparam lane_t LANE4 = 2'b11;

    localparam int NLANES = 4;

    // Same {sel2, sel1} encoding as the mux, so loopback is identity.
    function automatic lane_t sel_to_lane(input logic sel1, input logic sel2);
        return lane_t'({sel2, sel1});
    endfunction

endpackage

// File: rtl/demux4_lane_fifo.sv
// demux4_lane_fifo: one output lane, a DEPTH-entry synchronous FIFO.
// Pointers wrap naturally because DEPTH is a power of two.
module demux4_lane_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 2,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             valid,
    output logic [WIDTH-1:0] head_data,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wp;
    logic [AW-1:0]    rp;
    logic             push_ok;
    logic             pop_ok;

    assign full      = (count == CW'(DEPTH));
    assign valid     = (count != '0);
    assign head_data = mem[rp];
    assign push_ok   = push && !full;
    assign pop_ok    = pop && valid;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (push_ok) wp <= wp + AW'(1);
            if (pop_ok)  rp <= rp + AW'(1);
            unique case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is not reset; count gates visibility.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wp] <= push_data;
    end

endmodule

// File: rtl/demux4_router.sv
// demux4_router: 1-to-4 streaming demux with a FIFO per lane.
// A full lane only backpressures beats that select it.
module demux4_router
    import demux4_router_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 2,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             sel1,
    input  logic             sel2,
    output logic             o1_valid,
    output logic             o2_valid,
    output logic             o3_valid,
    output logic             o4_valid,
    input  logic             o1_ready,
    input  logic             o2_ready,
    input  logic             o3_ready,
    input  logic             o4_ready,
    output logic [WIDTH-1:0] o1_data,
    output logic [WIDTH-1:0] o2_data,
    output logic [WIDTH-1:0] o3_data,
    output logic [WIDTH-1:0] o4_data,
    output logic [CW-1:0]    o1_count,
    output logic [CW-1:0]    o2_count,
    output logic [CW-1:0]    o3_count,
    output logic [CW-1:0]    o4_count,
    output logic             drop_sel
);

    lane_t            lane;
    logic [3:0]       full;
    logic [3:0]       valid;
    logic [3:0]       push;
    logic [3:0]       pop;
    logic [WIDTH-1:0] head [NLANES];
    logic [CW-1:0]    cnt  [NLANES];

    assign lane     = sel_to_lane(sel1, sel2);
    assign in_ready = rst_n && !full[lane];
    assign pop      = {o4_ready, o3_ready, o2_ready, o1_ready} & valid;

    always_comb begin
        push = '0;
        if (in_valid && in_ready) push[lane] = 1'b1;
    end

    for (genvar g = 0; g < NLANES; g++) begin : g_lane
        demux4_lane_fifo #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk       (clk),
            .rst_n     (rst_n),
            .push      (push[g]),
            .push_data (in_data),
            .pop       (pop[g]),
            .full      (full[g]),
            .valid     (valid[g]),
            .head_data (head[g]),
            .count     (cnt[g])
        );
    end

    assign o1_valid = valid[LANE1];
    assign o2_valid = valid[LANE2];
    assign o3_valid = valid[LANE3];
    assign o4_valid = valid[LANE4];
    assign o1_data  = head[LANE1];
    assign o2_data  = head[LANE2];
    assign o3_data  = head[LANE3];
    assign o4_data  = head[LANE4];
    assign o1_count = cnt[LANE1];
    assign o2_count = cnt[LANE2];
    assign o3_count = cnt[LANE3];
    assign o4_count = cnt[LANE4];

    // Diagnostic only: the producer keeps holding the beat.
    always_ff @(posedge clk) begin
        if (!rst_n)                       drop_sel <= 1'b0;
        else if (in_valid && full[lane])  drop_sel <= 1'b1;
    end

endmodule

// File: tb/tb_demux4_router.sv
// Directed vector bench for demux4_router (WIDTH=8, DEPTH=2).
// Table rows cover streaming cases; reset cases are hand sequences.
module tb_demux4_router;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       sel1, sel2;
    logic       o1_valid, o2_valid, o3_valid, o4_valid;
    logic       o1_ready, o2_ready, o3_ready, o4_ready;
    logic [7:0] o1_data, o2_data, o3_data, o4_data;
    logic [1:0] o1_count, o2_count, o3_count, o4_count;
    logic       drop_sel;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    demux4_router #(.WIDTH(8), .DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .sel1(sel1), .sel2(sel2),
        .o1_valid(o1_valid), .o2_valid(o2_valid),
        .o3_valid(o3_valid), .o4_valid(o4_valid),
        .o1_ready(o1_ready), .o2_ready(o2_ready),
        .o3_ready(o3_ready), .o4_ready(o4_ready),
        .o1_data(o1_data), .o2_data(o2_data),
        .o3_data(o3_data), .o4_data(o4_data),
        .o1_count(o1_count), .o2_count(o2_count),
        .o3_count(o3_count), .o4_count(o4_count),
        .drop_sel(drop_sel)
    );

    typedef struct {
        logic        v;
        logic [1:0]  s;
        logic [7:0]  d;
        logic [3:0]  r;
        logic        er;
        logic [3:0]  ev;
        logic [7:0]  ec;
        logic [31:0] eh;
        logic        ed;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic v, logic [1:0] s, logic [7:0] d,
                                logic [3:0] r, logic er, logic [3:0] ev,
                                logic [7:0] ec, logic [31:0] eh, logic ed);
        vec_t t;
        t.v = v; t.s = s; t.d = d; t.r = r; t.er = er;
        t.ev = ev; t.ec = ec; t.eh = eh; t.ed = ed;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] s,
                         input logic [7:0] d, input logic [3:0] r);
        in_valid = v;
        {sel2, sel1} = s;
        in_data = d;
        {o4_ready, o3_ready, o2_ready, o1_ready} = r;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] vals();
        return {o4_valid, o3_valid, o2_valid, o1_valid};
    endfunction

    function automatic logic [7:0] cnts();
        return {o4_count, o3_count, o2_count, o1_count};
    endfunction

    task automatic chk_state(input string tag, input logic [3:0] ev,
                             input logic [7:0] ec, input logic [31:0] eh,
                             input logic ed);
        logic [31:0] hd;
        hd = {o4_data, o3_data, o2_data, o1_data};
        chk({tag, " valid"}, 32'(vals()), 32'(ev));
        chk({tag, " count"}, 32'(cnts()), 32'(ec));
        chk({tag, " drop"},  32'(drop_sel), 32'(ed));
        for (int i = 0; i < 4; i++)
            if (ev[i]) chk($sformatf("%s data%0d", tag, i + 1),
                           32'(hd[i*8 +: 8]), 32'(eh[i*8 +: 8]));
    endtask

    initial begin
        // streaming: one beat per lane, all consumers ready
        vecs.push_back(mk(1, 2'b00, 8'h11, 4'b1111, 1, 4'b0001, 8'b00_00_00_01, 32'h00_00_00_11, 0));
        vecs.push_back(mk(1, 2'b01, 8'h22, 4'b1111, 1, 4'b0010, 8'b00_00_01_00, 32'h00_00_22_00, 0));
        vecs.push_back(mk(1, 2'b10, 8'h33, 4'b1111, 1, 4'b0100, 8'b00_01_00_00, 32'h00_33_00_00, 0));
        vecs.push_back(mk(1, 2'b11, 8'h44, 4'b1111, 1, 4'b1000, 8'b01_00_00_00, 32'h44_00_00_00, 0));
        // lane 3 stalled until full
        vecs.push_back(mk(1, 2'b10, 8'hA0, 4'b1011, 1, 4'b0100, 8'b00_01_00_00, 32'h00_A0_00_00, 0));
        vecs.push_back(mk(1, 2'b10, 8'hA1, 4'b1011, 1, 4'b0100, 8'b00_10_00_00, 32'h00_A0_00_00, 0));
        vecs.push_back(mk(1, 2'b10, 8'hA2, 4'b1011, 0, 4'b0100, 8'b00_10_00_00, 32'h00_A0_00_00, 1));
        // another lane still flows past the full one
        vecs.push_back(mk(1, 2'b01, 8'h55, 4'b1011, 1, 4'b0110, 8'b00_10_01_00, 32'h00_A0_55_00, 1));
        // drain lane 3, then A2 goes in behind A1
        vecs.push_back(mk(1, 2'b10, 8'hA2, 4'b1111, 0, 4'b0100, 8'b00_01_00_00, 32'h00_A1_00_00, 1));
        vecs.push_back(mk(1, 2'b10, 8'hA2, 4'b1111, 1, 4'b0100, 8'b00_01_00_00, 32'h00_A2_00_00, 1));
        vecs.push_back(mk(0, 2'b10, 8'h00, 4'b1111, 1, 4'b0000, 8'b00_00_00_00, 32'h0, 1));
        // lane 1: simultaneous push/pop, then wrap through 6 beats
        vecs.push_back(mk(1, 2'b00, 8'h66, 4'b1110, 1, 4'b0001, 8'b00_00_00_01, 32'h00_00_00_66, 1));
        vecs.push_back(mk(1, 2'b00, 8'h77, 4'b1111, 1, 4'b0001, 8'b00_00_00_01, 32'h00_00_00_77, 1));
        vecs.push_back(mk(1, 2'b00, 8'h81, 4'b1110, 1, 4'b0001, 8'b00_00_00_10, 32'h00_00_00_77, 1));
        vecs.push_back(mk(1, 2'b00, 8'h82, 4'b1110, 0, 4'b0001, 8'b00_00_00_10, 32'h00_00_00_77, 1));
        vecs.push_back(mk(1, 2'b00, 8'h82, 4'b1111, 0, 4'b0001, 8'b00_00_00_01, 32'h00_00_00_81, 1));
        vecs.push_back(mk(1, 2'b00, 8'h82, 4'b1111, 1, 4'b0001, 8'b00_00_00_01, 32'h00_00_00_82, 1));
        vecs.push_back(mk(1, 2'b00, 8'h83, 4'b1111, 1, 4'b0001, 8'b00_00_00_01, 32'h00_00_00_83, 1));
        vecs.push_back(mk(1, 2'b00, 8'h84, 4'b1110, 1, 4'b0001, 8'b00_00_00_10, 32'h00_00_00_83, 1));
        vecs.push_back(mk(1, 2'b00, 8'h85, 4'b1111, 0, 4'b0001, 8'b00_00_00_01, 32'h00_00_00_84, 1));
        vecs.push_back(mk(1, 2'b00, 8'h85, 4'b1111, 1, 4'b0001, 8'b00_00_00_01, 32'h00_00_00_85, 1));
        vecs.push_back(mk(1, 2'b00, 8'h86, 4'b1111, 1, 4'b0001, 8'b00_00_00_01, 32'h00_00_00_86, 1));
        vecs.push_back(mk(0, 2'b00, 8'h00, 4'b1111, 1, 4'b0000, 8'b00_00_00_00, 32'h0, 1));

        // reset held with a beat offered
        rst_n = 1'b0;
        drive(1, 2'b00, 8'h99, 4'b1111);
        #1;
        chk("rst ready", 32'(in_ready), 32'd0);
        step();
        step();
        chk("rst ready2", 32'(in_ready), 32'd0);
        chk_state("rst", 4'b0000, 8'h00, 32'h0, 0);
        rst_n = 1'b1;
        drive(0, 2'b00, 8'h00, 4'b1111);
        #1;
        chk("rel ready", 32'(in_ready), 32'd1);

        foreach (vecs[i]) begin
            drive(vecs[i].v, vecs[i].s, vecs[i].d, vecs[i].r);
            #1;
            chk($sformatf("v%0d ready", i), 32'(in_ready), 32'(vecs[i].er));
            step();
            chk_state($sformatf("v%0d", i), vecs[i].ev, vecs[i].ec,
                      vecs[i].eh, vecs[i].ed);
        end

        // fill lanes 1 and 4, then reset mid-transfer
        drive(1, 2'b00, 8'hC1, 4'b0000);
        step();
        drive(1, 2'b11, 8'hC4, 4'b0000);
        step();
        drive(1, 2'b11, 8'hC5, 4'b0000);
        step();
        chk_state("pre", 4'b1001, 8'b10_00_00_01, 32'hC4_00_00_C1, 1);
        rst_n = 1'b0;
        drive(1, 2'b00, 8'hEE, 4'b0000);
        #1;
        chk("mid ready", 32'(in_ready), 32'd0);
        step();
        chk_state("mid", 4'b0000, 8'h00, 32'h0, 0);
        rst_n = 1'b1;
        drive(0, 2'b00, 8'h00, 4'b1111);
        for (int k = 0; k < 3; k++) begin
            step();
            chk_state($sformatf("post%0d", k), 4'b0000, 8'h00, 32'h0, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
